// File: rtl/rsa_keygen_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_keygen_ctrl
// Sequencer for RSA private-key generation around a shared modular-inverse
// unit. It latches p, q and e, forms n = p*q and phi = (p-1)*(q-1), asks the
// inverse unit for d = e^-1 mod phi, confirms that e*d mod phi == 1, and then
// reports n, d and a status code.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   start                    request pulse, taken only in IDLE
//   p_in, q_in  [HALF]       primes
//   e_in        [WIDTH]      public exponent
//   busy                     high from accepted start until the DONE cycle
//   done                     one-cycle completion pulse
//   err_code    [3]          0 ok, 1 bad prime, 2 e out of range,
//                            3 timeout, 4 check fail
//   n_out, d_out [WIDTH]     modulus / private exponent (d_out = 0 on error)
//   inv_start                one-cycle request to the inverse unit
//   inv_num, inv_mod [WIDTH] inverse operands (e, phi), held after ISSUE
//   inv_done                 inverse-unit done level
//   inv_result  [WIDTH]      inverse-unit result, valid while inv_done = 1
// ---------------------------------------------------------------------------
module rsa_keygen_ctrl #(
    parameter int unsigned WIDTH   = 512,
    parameter int unsigned HALF    = WIDTH / 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic [HALF-1:0]  p_in,
    input  logic [HALF-1:0]  q_in,
    input  logic [WIDTH-1:0] e_in,
    output logic             busy,
    output logic             done,
    output logic [2:0]       err_code,
    output logic [WIDTH-1:0] n_out,
    output logic [WIDTH-1:0] d_out,
    output logic             inv_start,
    output logic [WIDTH-1:0] inv_num,
    output logic [WIDTH-1:0] inv_mod,
    input  logic             inv_done,
    input  logic [WIDTH-1:0] inv_result
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_PRIME = 3'd1;
    localparam logic [2:0] ERR_RANGE = 3'd2;
    localparam logic [2:0] ERR_TMO   = 3'd3;
    localparam logic [2:0] ERR_CHECK = 3'd4;

    // State and datapath registers
    logic [2:0]       r_state;
    logic [HALF-1:0]  r_p;
    logic [HALF-1:0]  r_q;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_phi;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_arm;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_err_code;
    logic [WIDTH-1:0] r_n_out;
    logic [WIDTH-1:0] r_d_out;
    logic             r_inv_start;
    logic [WIDTH-1:0] r_inv_num;
    logic [WIDTH-1:0] r_inv_mod;

    // Next-state values
    logic [2:0]       w_state_nxt;
    logic [HALF-1:0]  w_p_nxt;
    logic [HALF-1:0]  w_q_nxt;
    logic [WIDTH-1:0] w_e_nxt;
    logic [WIDTH-1:0] w_n_nxt;
    logic [WIDTH-1:0] w_phi_nxt;
    logic [WIDTH-1:0] w_d_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_arm_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [2:0]       w_err_code_nxt;
    logic [WIDTH-1:0] w_n_out_nxt;
    logic [WIDTH-1:0] w_d_out_nxt;
    logic             w_inv_start_nxt;
    logic [WIDTH-1:0] w_inv_num_nxt;
    logic [WIDTH-1:0] w_inv_mod_nxt;

    // Completion request raised by whichever state finishes the run
    logic             w_to_done;
    logic [2:0]       w_fin_err;
    logic [WIDTH-1:0] w_fin_n;

    // Arithmetic on the latched operands
    logic [HALF-1:0]  w_p_m1;
    logic [HALF-1:0]  w_q_m1;
    logic [WIDTH-1:0] w_n;
    logic [WIDTH-1:0] w_phi;
    logic [W2-1:0]    w_prod;
    logic [W2-1:0]    w_rem;

    // Both products are HALF x HALF, so WIDTH bits hold them exactly
    assign w_p_m1 = r_p - HALF'(1);
    assign w_q_m1 = r_q - HALF'(1);
    assign w_n    = WIDTH'(r_p) * WIDTH'(r_q);
    assign w_phi  = WIDTH'(w_p_m1) * WIDTH'(w_q_m1);

    // Verification product e*d mod phi; phi is never 0 once CHECK is reachable
    assign w_prod = W2'(r_e) * W2'(r_d);
    assign w_rem  = (r_phi == '0) ? '0 : (w_prod % W2'(r_phi));

    // Next-state and output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_p_nxt         = r_p;
        w_q_nxt         = r_q;
        w_e_nxt         = r_e;
        w_n_nxt         = r_n;
        w_phi_nxt       = r_phi;
        w_d_nxt         = r_d;
        w_cnt_nxt       = r_cnt;
        w_arm_nxt       = r_arm;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_err_code_nxt  = r_err_code;
        w_n_out_nxt     = r_n_out;
        w_d_out_nxt     = r_d_out;
        w_inv_start_nxt = 1'b0;
        w_inv_num_nxt   = r_inv_num;
        w_inv_mod_nxt   = r_inv_mod;
        w_to_done       = 1'b0;
        w_fin_err       = ERR_OK;
        w_fin_n         = r_n;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_p_nxt     = p_in;
                    w_q_nxt     = q_in;
                    w_e_nxt     = e_in;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_PREP;
                end
            end

            S_PREP: begin
                w_n_nxt   = w_n;
                w_phi_nxt = w_phi;
                w_fin_n   = w_n;
                if ((r_p < HALF'(2)) || (r_q < HALF'(2))) begin
                    w_to_done = 1'b1;
                    w_fin_err = ERR_PRIME;
                end else if ((r_e == '0) || (r_e >= w_phi)) begin
                    w_to_done = 1'b1;
                    w_fin_err = ERR_RANGE;
                end else begin
                    // Operands registered together with the start pulse
                    w_inv_start_nxt = 1'b1;
                    w_inv_num_nxt   = r_e;
                    w_inv_mod_nxt   = w_phi;
                    w_state_nxt     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_cnt_nxt   = '0;
                w_arm_nxt   = 1'b0;
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // A done level only counts after it has been seen low once
                if (!inv_done) begin
                    w_arm_nxt = 1'b1;
                end
                if (inv_done && r_arm) begin
                    w_d_nxt     = inv_result;
                    w_state_nxt = S_CHECK;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_to_done = 1'b1;
                    w_fin_err = ERR_TMO;
                end
            end

            S_CHECK: begin
                w_to_done = 1'b1;
                w_fin_err = (w_rem == W2'(1)) ? ERR_OK : ERR_CHECK;
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Result registers change only on entry to DONE
        if (w_to_done) begin
            w_state_nxt    = S_DONE;
            w_done_nxt     = 1'b1;
            w_busy_nxt     = 1'b0;
            w_err_code_nxt = w_fin_err;
            w_n_out_nxt    = w_fin_n;
            w_d_out_nxt    = (w_fin_err == ERR_OK) ? r_d : '0;
        end
    end

    // State and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_q         <= '0;
            r_e         <= '0;
            r_n         <= '0;
            r_phi       <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_arm       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_code  <= ERR_OK;
            r_n_out     <= '0;
            r_d_out     <= '0;
            r_inv_start <= 1'b0;
            r_inv_num   <= '0;
            r_inv_mod   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_p         <= w_p_nxt;
            r_q         <= w_q_nxt;
            r_e         <= w_e_nxt;
            r_n         <= w_n_nxt;
            r_phi       <= w_phi_nxt;
            r_d         <= w_d_nxt;
            r_cnt       <= w_cnt_nxt;
            r_arm       <= w_arm_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err_code  <= w_err_code_nxt;
            r_n_out     <= w_n_out_nxt;
            r_d_out     <= w_d_out_nxt;
            r_inv_start <= w_inv_start_nxt;
            r_inv_num   <= w_inv_num_nxt;
            r_inv_mod   <= w_inv_mod_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err_code  = r_err_code;
    assign n_out     = r_n_out;
    assign d_out     = r_d_out;
    assign inv_start = r_inv_start;
    assign inv_num   = r_inv_num;
    assign inv_mod   = r_inv_mod;

endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rsa_keygen_ctrl
// Bench for rsa_keygen_ctrl at WIDTH=32, TIMEOUT=64. A behavioural inverse
// unit answers inv_start after a programmable delay; expected results come
// from a hand table and from an arithmetic key-generation model.
// ---------------------------------------------------------------------------
module tb_rsa_keygen_ctrl;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned HALF    = 16;
    localparam int unsigned TIMEOUT = 64;

    logic             aclk;
    logic             aresetn;
    logic             start;
    logic [HALF-1:0]  p_in;
    logic [HALF-1:0]  q_in;
    logic [WIDTH-1:0] e_in;
    logic             busy;
    logic             done;
    logic [2:0]       err_code;
    logic [WIDTH-1:0] n_out;
    logic [WIDTH-1:0] d_out;
    logic             inv_start;
    logic [WIDTH-1:0] inv_num;
    logic [WIDTH-1:0] inv_mod;
    logic             inv_done;
    logic [WIDTH-1:0] inv_result;

    rsa_keygen_ctrl #(.WIDTH(WIDTH), .HALF(HALF), .TIMEOUT(TIMEOUT)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .p_in(p_in), .q_in(q_in), .e_in(e_in),
        .busy(busy), .done(done), .err_code(err_code),
        .n_out(n_out), .d_out(d_out),
        .inv_start(inv_start), .inv_num(inv_num), .inv_mod(inv_mod),
        .inv_done(inv_done), .inv_result(inv_result)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    longint cyc = 0;
    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural inverse unit ----------------
    int unsigned rs_hold = 0;
    int unsigned rs_delay = 10;
    bit          rs_never = 1'b0;
    bit          rs_idle_level = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rs_stale_val = '0;
    int unsigned n_inv_start = 0;
    longint      istart_cyc = 0;
    longint      raise_cyc = 0;
    logic [31:0] cap_num = '0;
    logic [31:0] cap_mod = '0;

    initial begin
        bit          active;
        bit          phase;
        int unsigned hcnt;
        int unsigned dcnt;
        active = 1'b0; phase = 1'b0; hcnt = 0; dcnt = 0;
        inv_done = 1'b0;
        inv_result = '0;
        forever begin
            @(negedge aclk);
            if (inv_start) begin
                n_inv_start++;
                istart_cyc = cyc;
                cap_num = inv_num;
                cap_mod = inv_mod;
                active = 1'b1;
                hcnt = rs_hold;
                dcnt = rs_delay;
                if (rs_hold == 0) begin
                    inv_done = 1'b0;
                    phase = 1'b1;
                end else begin
                    phase = 1'b0;
                end
            end else if (active) begin
                if (!phase) begin
                    hcnt--;
                    if (hcnt == 0) begin
                        inv_done = 1'b0;
                        phase = 1'b1;
                    end
                end else if (!rs_never) begin
                    if (dcnt == 0) begin
                        inv_done = 1'b1;
                        inv_result = rs_val;
                        raise_cyc = cyc;
                        active = 1'b0;
                    end else begin
                        dcnt--;
                    end
                end
            end else begin
                inv_done = rs_idle_level;
                inv_result = rs_idle_level ? rs_stale_val : '0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic longint modinv(input longint a, input longint m);
        longint t, nt, r, nr, qq, tmp;
        t = 0; nt = 1; r = m; nr = a % m;
        while (nr != 0) begin
            qq = r / nr;
            tmp = t - qq * nt; t = nt; nt = tmp;
            tmp = r - qq * nr; r = nr; nr = tmp;
        end
        if (r != 1) return 0;
        if (t < 0) t = t + m;
        return t;
    endfunction

    task automatic ref_model(input logic [15:0] p, input logic [15:0] q, input logic [31:0] e,
                             input logic [31:0] inv, input bit never,
                             output logic [2:0] xerr, output logic [31:0] xn,
                             output logic [31:0] xd, output logic [31:0] xphi);
        logic [63:0] prod;
        xn = 32'(p) * 32'(q);
        xd = '0;
        xphi = '0;
        if (p < 2 || q < 2) begin
            xerr = 3'd1;
        end else begin
            xphi = 32'(p - 16'd1) * 32'(q - 16'd1);
            if (e == 0 || e >= xphi) xerr = 3'd2;
            else if (never) xerr = 3'd3;
            else begin
                prod = 64'(e) * 64'(inv);
                if (prod % 64'(xphi) != 64'd1) xerr = 3'd4;
                else begin
                    xerr = 3'd0;
                    xd = inv;
                end
            end
        end
    endtask

    // ---------------- transaction driver ----------------
    logic [2:0]  g_err;
    logic [31:0] g_n;
    logic [31:0] g_d;
    longint      g_t0;
    longint      g_tdone;
    int unsigned g_issued;

    task automatic do_run(input string tag, input logic [15:0] p, input logic [15:0] q,
                          input logic [31:0] e, input logic [31:0] val,
                          input int unsigned delay, input int unsigned hold,
                          input bit never, input bit spam, input bit start_in_done);
        int unsigned base;
        bit got;
        rs_val = val; rs_delay = delay; rs_hold = hold; rs_never = never;
        base = n_inv_start;
        p_in = p; q_in = q; e_in = e;
        start = 1'b1;
        g_t0 = cyc;
        @(negedge aclk);
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                got = 1'b1;
                g_tdone = cyc;
                g_err = err_code; g_n = n_out; g_d = d_out;
                start = start_in_done;
                break;
            end
            start = spam && (k % 3 == 1);
            if (spam) begin
                p_in = 16'd1; q_in = 16'd7; e_in = 32'd5;
            end
            @(negedge aclk);
        end
        if (!got) begin
            chk({tag, ".done_seen"}, 64'(got), 64'd1);
            start = 1'b0;
        end else begin
            @(negedge aclk);
            start = 1'b0;
            chk({tag, ".post_done_busy_done"}, {62'd0, busy, done}, 64'd0);
        end
        g_issued = n_inv_start - base;
    endtask

    task automatic verify(input string tag, input logic [2:0] xerr, input logic [31:0] xn,
                          input logic [31:0] xd, input logic [31:0] xphi, input logic [31:0] e);
        chk({tag, ".err_code"}, 64'(g_err), 64'(xerr));
        chk({tag, ".n_out"}, 64'(g_n), 64'(xn));
        chk({tag, ".d_out"}, 64'(g_d), 64'(xd));
        if (xerr == 3'd1 || xerr == 3'd2) begin
            chk({tag, ".inv_start_count"}, 64'(g_issued), 64'd0);
            chk({tag, ".err_latency"}, 64'(g_tdone - g_t0), 64'd2);
        end else begin
            chk({tag, ".inv_start_count"}, 64'(g_issued), 64'd1);
            chk({tag, ".inv_num"}, 64'(cap_num), 64'(e));
            chk({tag, ".inv_mod"}, 64'(cap_mod), 64'(xphi));
            chk({tag, ".issue_cycle"}, 64'(istart_cyc - g_t0), 64'd2);
            if (xerr == 3'd3)
                chk({tag, ".timeout_latency"}, 64'(g_tdone - istart_cyc - 1), 64'(TIMEOUT));
            else
                chk({tag, ".accept_latency"}, 64'(g_tdone - raise_cyc), 64'd2);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [15:0] p;
        logic [15:0] q;
        logic [31:0] e;
        logic [31:0] val;
        int unsigned delay;
        bit          never;
        logic [2:0]  err;
        logic [31:0] n;
        logic [31:0] d;
        logic [31:0] phi;
    } vec_t;

    vec_t tbl [13];

    logic [15:0] primes [16] = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd53, 16'd61,
                                 16'd101, 16'd251, 16'd257, 16'd1009, 16'd4093, 16'd32749,
                                 16'd65519, 16'd65521};

    initial begin
        logic [2:0]  xerr;
        logic [31:0] xn, xd, xphi, re, rinv, tphi;
        logic [15:0] rp, rq;
        bit          rnever;
        int          done_seen;
        int unsigned base;

        tbl[0]  = '{16'd61, 16'd53, 32'd17,   32'd2753, 10, 1'b0, 3'd0, 32'd3233, 32'd2753, 32'd3120};
        tbl[1]  = '{16'd1,  16'd53, 32'd17,   32'd2753, 10, 1'b0, 3'd1, 32'd53,   32'd0,    32'd0};
        tbl[2]  = '{16'd61, 16'd0,  32'd17,   32'd2753, 10, 1'b0, 3'd1, 32'd0,    32'd0,    32'd0};
        tbl[3]  = '{16'd2,  16'd2,  32'd1,    32'd1,    10, 1'b0, 3'd2, 32'd4,    32'd0,    32'd0};
        tbl[4]  = '{16'd61, 16'd53, 32'd3120, 32'd1,    10, 1'b0, 3'd2, 32'd3233, 32'd0,    32'd0};
        tbl[5]  = '{16'd61, 16'd53, 32'd0,    32'd1,    10, 1'b0, 3'd2, 32'd3233, 32'd0,    32'd0};
        tbl[6]  = '{16'd61, 16'd53, 32'd3119, 32'd3119, 5,  1'b0, 3'd0, 32'd3233, 32'd3119, 32'd3120};
        tbl[7]  = '{16'd61, 16'd53, 32'd17,   32'd2753, 10, 1'b1, 3'd3, 32'd3233, 32'd0,    32'd3120};
        tbl[8]  = '{16'd61, 16'd53, 32'd17,   32'd2752, 10, 1'b0, 3'd4, 32'd3233, 32'd0,    32'd3120};
        tbl[9]  = '{16'd61, 16'd53, 32'd15,   32'd0,    10, 1'b0, 3'd4, 32'd3233, 32'd0,    32'd3120};
        tbl[10] = '{16'd61, 16'd53, 32'd17,   32'd2753, 63, 1'b0, 3'd0, 32'd3233, 32'd2753, 32'd3120};
        tbl[11] = '{16'd61, 16'd53, 32'd17,   32'd2753, 64, 1'b0, 3'd3, 32'd3233, 32'd0,    32'd3120};
        tbl[12] = '{16'd3,  16'd5,  32'd3,    32'd3,    1,  1'b0, 3'd0, 32'd15,   32'd3,    32'd8};

        aresetn = 1'b0;
        start = 1'b0;
        p_in = '0; q_in = '0; e_in = '0;
        repeat (3) @(negedge aclk);
        chk("reset.ctrl", {58'd0, busy, done, inv_start, err_code}, 64'd0);
        chk("reset.n_d", {n_out, d_out}, 64'd0);
        chk("reset.inv_ops", {inv_num, inv_mod}, 64'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        for (int i = 0; i < 13; i++) begin
            do_run($sformatf("vec%0d", i), tbl[i].p, tbl[i].q, tbl[i].e, tbl[i].val,
                   tbl[i].delay, 0, tbl[i].never, 1'b0, 1'b0);
            verify($sformatf("vec%0d", i), tbl[i].err, tbl[i].n, tbl[i].d, tbl[i].phi, tbl[i].e);
            @(negedge aclk);
        end

        // Stale high done level, start spam while busy, start in the DONE cycle
        rs_idle_level = 1'b1;
        rs_stale_val = 32'd2752;
        repeat (3) @(negedge aclk);
        do_run("stale", 16'd61, 16'd53, 32'd17, 32'd2753, 4, 3, 1'b0, 1'b1, 1'b1);
        verify("stale", 3'd0, 32'd3233, 32'd2753, 32'd3120, 32'd17);
        @(negedge aclk);
        chk("stale.no_restart_busy", 64'(busy), 64'd0);
        rs_idle_level = 1'b0;
        repeat (3) @(negedge aclk);

        // Asynchronous reset in the middle of WAIT
        rs_val = 32'd2753; rs_delay = 10; rs_hold = 0; rs_never = 1'b0;
        base = n_inv_start;
        p_in = 16'd61; q_in = 16'd53; e_in = 32'd17;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        for (int k = 0; k < 10 && n_inv_start == base; k++) @(negedge aclk);
        chk("rst_mid.issued", 64'(n_inv_start - base), 64'd1);
        repeat (3) @(negedge aclk);
        chk("rst_mid.busy_before", 64'(busy), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid.ctrl", {58'd0, busy, done, inv_start, err_code}, 64'd0);
        chk("rst_mid.n_d", {n_out, d_out}, 64'd0);
        chk("rst_mid.inv_ops", {inv_num, inv_mod}, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            if (done || busy) done_seen++;
        end
        chk("rst_mid.quiet_after", 64'(done_seen), 64'd0);
        do_run("rst_after", 16'd61, 16'd53, 32'd17, 32'd2753, 10, 0, 1'b0, 1'b0, 1'b0);
        verify("rst_after", 3'd0, 32'd3233, 32'd2753, 32'd3120, 32'd17);
        @(negedge aclk);

        // Randomised runs against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 19);
            rp = (sel == 0) ? 16'd1 : (sel == 1) ? 16'd0 : primes[$urandom_range(0, 15)];
            rq = primes[$urandom_range(0, 15)];
            tphi = (rp >= 2) ? 32'(rp - 16'd1) * 32'(rq - 16'd1) : 32'd0;
            sel = $urandom_range(0, 9);
            case (sel)
                0: re = 32'd0;
                1: re = tphi;
                2: re = 32'd65537;
                3: re = 32'd3;
                default: re = (tphi >= 2) ? $urandom_range(1, tphi - 1) : 32'd1;
            endcase
            rinv = 32'd0;
            if (tphi >= 2 && re != 0 && re < tphi) begin
                rinv = 32'(modinv(longint'(re), longint'(tphi)));
                if ($urandom_range(0, 4) == 0) rinv = 32'((64'(rinv) + 64'd1) % 64'(tphi));
            end
            rnever = ($urandom_range(0, 9) == 0);
            ref_model(rp, rq, re, rinv, rnever, xerr, xn, xd, xphi);
            do_run($sformatf("rnd%0d", i), rp, rq, re, rinv, $urandom_range(1, 20), 0,
                   rnever, 1'b0, 1'b0);
            verify($sformatf("rnd%0d", i), xerr, xn, xd, xphi, re);
            @(negedge aclk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rsa_keygen_ctrl.md
Name: rsa_keygen_ctrl

Overview:
- Sequencer for RSA private-key generation around the shared modular-inverse datapath.
- Latches primes p, q and public exponent e, then computes n = p*q and phi = (p-1)*(q-1).
- Drives the inverse unit with (num = e, mod = phi) and waits for its done flag.
- Checks that e*d mod phi == 1, then returns n and d with a done/error status to the top-level key manager.

Parameters:
- WIDTH, 512: width of n, phi, e, d. Must be even. Bench uses 32.
- HALF, WIDTH/2: width of p and q.
- TIMEOUT, 4096: maximum number of cycles spent in WAIT before aborting.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset. Asynchronous, active-low.
- start  in  1  request pulse. Accepted only when busy=0.
- p_in  in  HALF  prime p.
- q_in  in  HALF  prime q.
- e_in  in  WIDTH  public exponent.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle completion pulse.
- err_code  out  3  0 ok, 1 bad prime, 2 e out of range, 3 timeout, 4 check fail.
- n_out  out  WIDTH  modulus.
- d_out  out  WIDTH  private exponent. Forced to 0 whenever err_code != 0.
- inv_start  out  1  one-cycle pulse to the inverse unit.
- inv_num  out  WIDTH  operand e. Held stable from ISSUE until WAIT exits.
- inv_mod  out  WIDTH  operand phi. Held stable from ISSUE until WAIT exits.
- inv_done  in  1  inverse-unit done flag (level; may remain high between runs).
- inv_result  in  WIDTH  inverse of inv_num modulo inv_mod. Valid while inv_done=1.

Behaviour:
- Reset (asynchronous, aresetn=0): state=IDLE. busy, done, inv_start = 0. err_code, n_out, d_out, inv_num, inv_mod = 0. Internal timeout counter and arm flag cleared. Reset mid-operation abandons the run; no done pulse is issued.
- Outputs n_out, d_out and err_code hold their values until the next accepted start.
- IDLE:
  - start=1 → latch p, q, e; set busy=1; go to PREP.
  - start while busy=1 is ignored (no queueing).
- PREP (1 cycle):
  - Register n = p*q and phi = (p-1)*(q-1). Products are full WIDTH, no truncation.
  - Checks are made on the latched inputs. If p<2 or q<2 → err 1. Else if e==0 or e>=phi → err 2.
  - Any error → DONE; inv_start is never asserted. Otherwise → ISSUE.
- ISSUE (1 cycle):
  - inv_start=1 with inv_num=e and inv_mod=phi.
  - Clear the counter and the arm flag; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - arm is set on the first cycle in which inv_done=0. This ensures a stale high done level from a previous run is never accepted.
  - inv_done=1 with arm=1 → latch inv_result into d; go to CHECK.
  - Counter reaching TIMEOUT-1 without acceptance → err 3; go to DONE.
  - If acceptance and timeout occur in the same cycle, acceptance wins.
  - inv_done is ignored in every state except WAIT.
- CHECK (1 cycle):
  - Compute (e*d) mod phi using a 2*WIDTH product.
  - Result != 1 (this also covers gcd(e, phi) != 1 and d >= phi) → err 4. Otherwise err 0.
  - → DONE.
- DONE (1 cycle):
  - done=1. n_out and err_code updated. d_out = d if err_code = 0, else 0.
  - busy falls in this cycle; return to IDLE.
  - A start arriving in the DONE cycle is ignored. start is accepted from the next cycle.
- Latency on the success path: start accepted at edge 0. inv_start is high in cycle 2. If inv_done is accepted k cycles after WAIT entry, done asserts 2 cycles later.

Test Plan:
- WIDTH=32, p=61, q=53, e=17, inverse model returns 2753 after 10 cycles → exactly one inv_start pulse with inv_num=17, inv_mod=3120; then done=1, err_code=0, n_out=3233, d_out=2753.
- p=1, q=53, e=17 → done within 3 cycles of start, err_code=1, inv_start never asserted, d_out=0. Repeat with e=3120 (p=61, q=53) → err_code=2.
- inv_done held at 0 forever, TIMEOUT=64 → done exactly 64 cycles after WAIT entry, err_code=3, d_out=0. Next start runs normally.
- Inverse model returns 2752 → err_code=4, d_out=0. Separately, e=15 (gcd 15) with model returning 0 → err_code=4.
- inv_done stuck high from before start, dropping 3 cycles into WAIT, then rising with 2753 → stale level not accepted, d_out=2753, err_code=0. Start pulses during busy → ignored; inv_start count remains 1.
- aresetn pulsed low mid-WAIT → all outputs 0 immediately (asynchronous), no done pulse; a subsequent start completes normally.
